// File: rtl/spindle_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spindle_spi_scheduler
//  Purpose  : Shares one SPI serializer between up to four spindle afferent
//             channels. Each rising edge of the simulation tick snapshots every
//             enabled channel word; the words are then issued one at a time in
//             ascending channel order, with tx_sel steering each word onto its
//             own pin group.
//  Ports    : clk, reset_n            - clock, synchronous active-low reset
//             tick_i                  - simulation tick level (clk domain)
//             ch_en_i / ch_data_i     - per-channel enable and packed words
//             clear_err_i             - clears the sticky error flags
//             tx_busy_i / tx_done_i   - serializer handshake inputs
//             tx_start_o / tx_data_o  - serializer request and word
//             tx_sel_o                - channel index / pin-group select
//             frame_cnt_o             - completed frame counter (wraps)
//             overrun_o, timeout_err_o- sticky error flags
//             idle_o                  - scheduler is idle
//  Revision : 1.0 - initial release
// ============================================================================
module spindle_spi_scheduler #(
    parameter int NCH     = 2,
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic              clear_err_i,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic              tx_start_o,
    output logic [DW-1:0]     tx_data_o,
    output logic [1:0]        tx_sel_o,
    output logic [15:0]       frame_cnt_o,
    output logic              overrun_o,
    output logic              timeout_err_o,
    output logic              idle_o
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Lowest set bit of mask at or above position 'from'.
    // Result: {found, index}.
    function automatic logic [2:0] next_set(input logic [NCH-1:0] mask, input int from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= from)) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                tick_d_q;
    logic [NCH*DW-1:0]   shadow_q, shadow_d;
    logic [NCH-1:0]      en_s_q, en_s_d;
    logic [1:0]          idx_q, idx_d;
    logic [CW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [DW-1:0]       tx_data_q, tx_data_d;
    logic [1:0]          tx_sel_q, tx_sel_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                overrun_q, overrun_d;
    logic                timeout_err_q, timeout_err_d;
    logic                idle_q, idle_d;

    logic                w_tick_rise;
    logic                w_go_issue;
    logic [2:0]          w_pick;

    assign w_tick_rise = tick_i & ~tick_d_q;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        en_s_d        = en_s_q;
        idx_d         = idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        tx_sel_d      = tx_sel_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        w_go_issue    = 1'b0;
        w_pick        = 3'b000;

        // Clear first so that a set condition in the same cycle wins.
        if (clear_err_i) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_tick_rise) begin
                    shadow_d = ch_data_i;
                    en_s_d   = ch_en_i;
                    w_pick   = next_set(ch_en_i, 0);
                    if (w_pick[2]) begin
                        idx_d      = w_pick[1:0];
                        w_go_issue = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_go_issue = 1'b1;
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
                if (tx_done_i || (tmo_cnt_q == TMO_LAST)) begin
                    if (!tx_done_i) begin
                        timeout_err_d = 1'b1;
                    end
                    w_pick = next_set(en_s_q, int'(idx_q) + 1);
                    if (w_pick[2]) begin
                        idx_d      = w_pick[1:0];
                        w_go_issue = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any tick edge while a frame is in flight is dropped and flagged.
        if (w_tick_rise && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        // Issue in the same cycle the word becomes due, so the start pulse
        // lands one cycle after the tick edge / previous tx_done. ISSUE is only
        // occupied while the serializer is busy, or to keep two start pulses
        // from landing back to back.
        if (w_go_issue) begin
            if (!tx_busy_i && !tx_start_q) begin
                tx_start_d = 1'b1;
                tx_data_d  = shadow_d[int'(idx_d)*DW +: DW];
                tx_sel_d   = idx_d;
                tmo_cnt_d  = '0;
                state_d    = S_WAIT;
            end else begin
                state_d = S_ISSUE;
            end
        end

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tick_d_q      <= 1'b0;
            shadow_q      <= '0;
            en_s_q        <= '0;
            idx_q         <= 2'd0;
            tmo_cnt_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_sel_q      <= 2'd0;
            frame_cnt_q   <= 16'd0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            tick_d_q      <= tick_i;
            shadow_q      <= shadow_d;
            en_s_q        <= en_s_d;
            idx_q         <= idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            tx_sel_q      <= tx_sel_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            idle_q        <= idle_d;
        end
    end

    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign tx_sel_o      = tx_sel_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;
    assign idle_o        = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_spindle_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spindle_spi_scheduler
//  Purpose  : Self-checking bench for spindle_spi_scheduler. A serializer
//             model answers tx_start with tx_done after a programmable delay;
//             expected {tx_sel, tx_data} words are queued when a tick is
//             driven and popped when tx_start is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spindle_spi_scheduler;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef logic [DW+1:0] exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              tick = 1'b0;
    logic [NCH-1:0]    ch_en = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic              clear_err = 1'b0;
    logic              tx_done = 1'b0;
    logic              ser_busy = 1'b0;
    logic              force_busy = 1'b0;
    wire               tx_busy = force_busy | ser_busy;

    logic              tx_start_o;
    logic [DW-1:0]     tx_data_o;
    logic [1:0]        tx_sel_o;
    logic [15:0]       frame_cnt_o;
    logic              overrun_o;
    logic              timeout_err_o;
    logic              idle_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_frames = 0;
    exp_t sb[$];
    int   start_cyc[$];
    int   idle_rise_cyc = 0;
    logic prev_start = 1'b0;
    logic prev_idle  = 1'b1;

    int   ser_cnt = 0;
    int   ser_lat = 12;
    bit   ser_on  = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    spindle_spi_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_i       (tick),
        .ch_en_i      (ch_en),
        .ch_data_i    (ch_data),
        .clear_err_i  (clear_err),
        .tx_busy_i    (tx_busy),
        .tx_done_i    (tx_done),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .tx_sel_o     (tx_sel_o),
        .frame_cnt_o  (frame_cnt_o),
        .overrun_o    (overrun_o),
        .timeout_err_o(timeout_err_o),
        .idle_o       (idle_o)
    );

    // Serializer model: busy from start, tx_done pulse ser_lat cycles later.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (ser_cnt > 0) begin
            ser_cnt = ser_cnt - 1;
            if (ser_cnt == 0) begin
                tx_done  = 1'b1;
                ser_busy = 1'b0;
            end
        end else if (tx_start_o && ser_on) begin
            ser_cnt  = ser_lat;
            ser_busy = 1'b1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (tx_start_o) begin
            start_cyc.push_back(cyc);
            n_checks++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL start_back_to_back: tx_start high in two consecutive cycles at cycle %0d", cyc);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: got sel=%0d data=%h, no word expected", tx_sel_o, tx_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({tx_sel_o, tx_data_o} !== e) begin
                    n_fail++;
                    $display("FAIL word: got sel=%0d data=%h, expected sel=%0d data=%h",
                             tx_sel_o, tx_data_o, e[DW+1:DW], e[DW-1:0]);
                end
            end
        end
        prev_start = tx_start_o;
        if (idle_o && !prev_idle) idle_rise_cyc = cyc;
        prev_idle = idle_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int k = 0; k < NCH; k++) begin
            if (ch_en[k]) sb.push_back({2'(k), ch_data[k*DW +: DW]});
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!idle_o && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (!idle_o) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: idle=%b after %0d cycles, expected 1", name, idle_o, budget);
        end
    endtask

    task automatic wait_until(input int target);
        int k = 0;
        while (cyc < target && k < 1000) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_checks += 7;
        if (tx_start_o !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b expected 0", tx_start_o); end
        if (tx_data_o !== '0) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 0", tx_data_o); end
        if (tx_sel_o !== 2'd0) begin n_fail++; $display("FAIL rst_tx_sel: got %0d expected 0", tx_sel_o); end
        if (frame_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt_o); end
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun_o); end
        if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err_o); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", idle_o); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_two_channels();
        int s0, c;
        ser_lat = 12;
        ch_en   = 2'b11;
        ch_data = {32'h42A0_0000, 32'h3F66_6666};
        push_frame();
        s0 = start_cyc.size();
        c  = cyc;
        pulse_tick();
        wait_idle(200, "two_ch");
        exp_frames++;
        n_checks += 6;
        if (start_cyc.size() != s0 + 2) begin n_fail++; $display("FAIL two_ch_starts: got %0d expected 2", start_cyc.size() - s0); end
        if (start_cyc[s0] != c + 1) begin n_fail++; $display("FAIL two_ch_first_latency: got cycle %0d expected %0d", start_cyc[s0], c + 1); end
        if (start_cyc[s0+1] != start_cyc[s0] + ser_lat + 1) begin n_fail++; $display("FAIL two_ch_second_latency: got cycle %0d expected %0d", start_cyc[s0+1], start_cyc[s0] + ser_lat + 1); end
        if (idle_rise_cyc != start_cyc[s0+1] + ser_lat + 1) begin n_fail++; $display("FAIL two_ch_idle_latency: got cycle %0d expected %0d", idle_rise_cyc, start_cyc[s0+1] + ser_lat + 1); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL two_ch_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL two_ch_pending: got %0d words outstanding expected 0", sb.size()); end
        step();
    endtask

    task automatic test_single_channel();
        int s0;
        logic [15:0] f0;
        ch_en = 2'b10;
        ch_data = {32'hC049_0FDB, 32'h1234_5678};
        s0 = start_cyc.size();
        for (int r = 0; r < 2; r++) begin
            push_frame();
            pulse_tick();
            wait_idle(200, "single");
            exp_frames++;
            step();
        end
        n_checks += 3;
        if (start_cyc.size() != s0 + 2) begin n_fail++; $display("FAIL single_starts: got %0d expected 2", start_cyc.size() - s0); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", sb.size()); end
        ch_en = 2'b00;
        s0 = start_cyc.size();
        f0 = frame_cnt_o;
        pulse_tick();
        n_checks++;
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL none_idle: got %b expected 1", idle_o); end
        repeat (20) step();
        n_checks += 2;
        if (start_cyc.size() != s0) begin n_fail++; $display("FAIL none_starts: got %0d expected 0", start_cyc.size() - s0); end
        if (frame_cnt_o !== f0) begin n_fail++; $display("FAIL none_frame_cnt: got %0d expected %0d", frame_cnt_o, f0); end
    endtask

    task automatic test_overrun();
        int s0;
        ser_lat = 12;
        ch_en   = 2'b11;
        ch_data = {32'hAAAA_5555, 32'h0F0F_F0F0};
        push_frame();
        s0 = start_cyc.size();
        pulse_tick();
        if (start_cyc.size() > s0) wait_until(start_cyc[s0] + 5);
        // Tick edge and clear in the same cycle: the set must win.
        tick = 1'b1;
        clear_err = 1'b1;
        step();
        tick = 1'b0;
        clear_err = 1'b0;
        n_checks++;
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun_o); end
        wait_idle(200, "ovr");
        exp_frames++;
        n_checks += 4;
        if (start_cyc.size() != s0 + 2) begin n_fail++; $display("FAIL ovr_starts: got %0d expected 2", start_cyc.size() - s0); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL ovr_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL ovr_pending: got %0d expected 0", sb.size()); end
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun_o); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_checks++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end

        // Tick edge in the very cycle the last tx_done returns WAIT to IDLE.
        ch_en = 2'b01;
        push_frame();
        s0 = start_cyc.size();
        pulse_tick();
        if (start_cyc.size() > s0) wait_until(start_cyc[s0] + ser_lat);
        tick = 1'b1;
        step();
        exp_frames++;
        n_checks += 3;
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_edge_set: got %b expected 1", overrun_o); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL ovr_edge_idle: got %b expected 1", idle_o); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL ovr_edge_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        tick = 1'b0;
        repeat (20) step();
        n_checks += 2;
        if (start_cyc.size() != s0 + 1) begin n_fail++; $display("FAIL ovr_edge_starts: got %0d expected 1", start_cyc.size() - s0); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL ovr_edge_pending: got %0d expected 0", sb.size()); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
    endtask

    task automatic test_timeout();
        int s0;
        ser_on  = 1'b0;
        ch_en   = 2'b11;
        ch_data = {32'h1111_2222, 32'h3333_4444};
        push_frame();
        s0 = start_cyc.size();
        pulse_tick();
        if (start_cyc.size() > s0) wait_until(start_cyc[s0] + TMO - 1);
        n_checks++;
        if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", timeout_err_o); end
        step();
        n_checks += 3;
        if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", timeout_err_o); end
        if (start_cyc.size() != s0 + 2) begin n_fail++; $display("FAIL tmo_next_issued: got %0d starts expected 2", start_cyc.size() - s0); end
        if (start_cyc[s0+1] != start_cyc[s0] + TMO) begin n_fail++; $display("FAIL tmo_next_cycle: got %0d expected %0d", start_cyc[s0+1], start_cyc[s0] + TMO); end
        wait_idle(200, "tmo");
        exp_frames++;
        n_checks += 2;
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL tmo_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL tmo_pending: got %0d expected 0", sb.size()); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_checks++;
        if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", timeout_err_o); end

        // tx_done in the last allowed cycle counts as completion.
        ser_on  = 1'b1;
        ser_lat = TMO - 1;
        push_frame();
        s0 = start_cyc.size();
        pulse_tick();
        wait_idle(200, "tmo_edge");
        exp_frames++;
        n_checks += 3;
        if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_err: got %b expected 0", timeout_err_o); end
        if (start_cyc[s0+1] != start_cyc[s0] + TMO) begin n_fail++; $display("FAIL tmo_edge_next: got %0d expected %0d", start_cyc[s0+1], start_cyc[s0] + TMO); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL tmo_edge_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        ser_lat = 12;
        step();
    endtask

    task automatic test_busy();
        int s0, b;
        ch_en = 2'b01;
        ch_data[0 +: DW] = 32'hDEAD_BEEF;
        force_busy = 1'b1;
        push_frame();
        s0 = start_cyc.size();
        b  = cyc;
        pulse_tick();
        repeat (2) step();
        ch_data[0 +: DW] = 32'hBAAD_F00D;
        repeat (7) step();
        n_checks++;
        if (start_cyc.size() != s0) begin n_fail++; $display("FAIL busy_held: got %0d starts expected 0", start_cyc.size() - s0); end
        force_busy = 1'b0;
        step();
        n_checks += 2;
        if (start_cyc.size() != s0 + 1) begin n_fail++; $display("FAIL busy_start: got %0d starts expected 1", start_cyc.size() - s0); end
        if (start_cyc[s0] != b + 11) begin n_fail++; $display("FAIL busy_latency: got cycle %0d expected %0d", start_cyc[s0], b + 11); end
        wait_idle(200, "busy");
        exp_frames++;
        n_checks += 2;
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL busy_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL busy_pending: got %0d expected 0", sb.size()); end
        step();
    endtask

    task automatic test_reset_midframe();
        int s0;
        ser_lat = 12;
        ch_en   = 2'b11;
        ch_data = {32'h7777_8888, 32'h5555_6666};
        push_frame();
        s0 = start_cyc.size();
        pulse_tick();
        if (start_cyc.size() > s0) wait_until(start_cyc[s0] + 4);
        reset_n = 1'b0;
        step();
        n_checks += 6;
        if (tx_start_o !== 1'b0) begin n_fail++; $display("FAIL mrst_tx_start: got %b expected 0", tx_start_o); end
        if (tx_data_o !== '0) begin n_fail++; $display("FAIL mrst_tx_data: got %h expected 0", tx_data_o); end
        if (tx_sel_o !== 2'd0) begin n_fail++; $display("FAIL mrst_tx_sel: got %0d expected 0", tx_sel_o); end
        if (frame_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mrst_frame_cnt: got %0d expected 0", frame_cnt_o); end
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL mrst_overrun: got %b expected 0", overrun_o); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL mrst_idle: got %b expected 1", idle_o); end
        reset_n = 1'b1;
        sb.delete();
        exp_frames = 0;
        s0 = start_cyc.size();
        repeat (20) step();
        n_checks += 2;
        if (start_cyc.size() != s0) begin n_fail++; $display("FAIL mrst_stale_done: got %0d starts expected 0", start_cyc.size() - s0); end
        if (idle_o !== 1'b1) begin n_fail++; $display("FAIL mrst_stay_idle: got %b expected 1", idle_o); end
        push_frame();
        pulse_tick();
        wait_idle(200, "mrst");
        exp_frames++;
        n_checks += 3;
        if (start_cyc.size() != s0 + 2) begin n_fail++; $display("FAIL mrst_fresh_starts: got %0d expected 2", start_cyc.size() - s0); end
        if (frame_cnt_o !== 16'(exp_frames)) begin n_fail++; $display("FAIL mrst_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_frames); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL mrst_pending: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_single_channel();
        test_overrun();
        test_timeout();
        test_busy();
        test_reset_midframe();
        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
